// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, in-order response FIFO to decode.
// Optional build macro FETCH_PERF_EN adds the perf_fetched / perf_bubbles counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] fetched_inst0,
  output logic [31:0] fetched_inst0_pc,
  output logic        fetched_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW+1:0] DEPTH_C = DEPTH[CW+1:0];
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc, resp_pc;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [CW+1:0] credit;
  logic          empty, issue, push, pop, drop, kill_resp;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty          = (count == '0);
  assign credit         = {2'b00, outstanding} + {2'b00, count} + {2'b00, drop_cnt};
  assign imem_req_valid = reset && !kill && (credit < DEPTH_C);
  assign imem_req_addr  = pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign drop           = imem_resp_valid && (drop_cnt != '0);
  assign push           = imem_resp_valid && !kill && (drop_cnt == '0) && (outstanding != '0);
  assign pop            = !kill && !stall && !empty;
  // A kill-cycle response retires one stale request, whether it was counted as outstanding or as drop.
  assign kill_resp      = imem_resp_valid && ((drop_cnt != '0) || (outstanding != '0));

  always_comb begin
    fetched_valid    = 1'b0;
    fetched_inst0    = NOP;
    fetched_inst0_pc = reset ? resp_pc : '0;
    if (!kill && !empty) begin
      fetched_valid    = 1'b1;
      fetched_inst0    = fifo_inst[rd_ptr];
      fetched_inst0_pc = fifo_pc[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (kill) begin
      pc          <= redirect_pc & ~32'h3;
      resp_pc     <= redirect_pc & ~32'h3;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + outstanding - {{(CW-1){1'b0}}, kill_resp};
    end else begin
      if (issue) pc <= pc + 32'd4;
      if (push) resp_pc <= resp_pc + 32'd4;
      if (drop) drop_cnt <= drop_cnt - CW'(1);
      case ({issue, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (kill) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (!kill) begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (!stall && empty) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

  resp_expected: assert property (@(posedge clk) disable iff (!reset)
    !(imem_resp_valid && (outstanding == '0) && (drop_cnt == '0)));
endmodule
